// File: rtl/regfile.sv
// 32 x RDATA_WIDTH integer register file: two bypassed read ports, one
// write port, a raw debug read port and a retired-writeback counter.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif
`ifndef WRITE_ENABLE
`define WRITE_ENABLE 1'b1
`endif
`ifndef WRITE_DISABLE
`define WRITE_DISABLE 1'b0
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif
`ifndef ZERO
`define ZERO 32'h0000_0000
`endif

module regfile (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [`RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                    reg_we_i,
    input  logic [`RDATA_WIDTH-1:0] reg_wdata_i,
    input  logic [`RADDR_WIDTH-1:0] reg1_raddr_i,
    input  logic [`RADDR_WIDTH-1:0] reg2_raddr_i,
    input  logic                    reg1_re_i,
    input  logic                    reg2_re_i,
    output logic [`RDATA_WIDTH-1:0] reg1_rdata_o,
    output logic [`RDATA_WIDTH-1:0] reg2_rdata_o,
    input  logic [`RADDR_WIDTH-1:0] dbg_raddr_i,
    output logic [`RDATA_WIDTH-1:0] dbg_rdata_o,
    output logic [31:0]             wb_count_o,
    input  logic                    wb_count_clr_i
);

    logic [`RDATA_WIDTH-1:0] regs [0:31];
    logic [31:0]             wb_count;
    logic                    wr_fire;

    // A write retires only when enabled and aimed at a real register.
    assign wr_fire = (reg_we_i == `WRITE_ENABLE) && (reg_waddr_i != `ZERO_REG);

    // x0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= `ZERO;
            end
        end else if (wr_fire) begin
            regs[reg_waddr_i] <= reg_wdata_i;
        end
    end

    // Clear wins over a same-cycle increment; the add wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_count <= 32'd0;
        end else if (wb_count_clr_i) begin
            wb_count <= 32'd0;
        end else if (wr_fire) begin
            wb_count <= wb_count + 32'd1;
        end
    end

    assign wb_count_o = wb_count;

    // Write-first read: the in-flight writeback is forwarded to the decoder.
    function automatic logic [`RDATA_WIDTH-1:0] read_port(
        input logic                    rst,
        input logic                    re,
        input logic [`RADDR_WIDTH-1:0] raddr,
        input logic                    fire,
        input logic [`RADDR_WIDTH-1:0] waddr,
        input logic [`RDATA_WIDTH-1:0] wdata,
        input logic [`RDATA_WIDTH-1:0] stored
    );
        logic [`RDATA_WIDTH-1:0] result;
        result = `ZERO;
        if (!rst && re && (raddr != `ZERO_REG)) begin
            if (fire && (raddr == waddr)) begin
                result = wdata;
            end else begin
                result = stored;
            end
        end
        return result;
    endfunction

    always_comb begin
        reg1_rdata_o = read_port(rst_i, reg1_re_i, reg1_raddr_i, wr_fire,
                                 reg_waddr_i, reg_wdata_i, regs[reg1_raddr_i]);
        reg2_rdata_o = read_port(rst_i, reg2_re_i, reg2_raddr_i, wr_fire,
                                 reg_waddr_i, reg_wdata_i, regs[reg2_raddr_i]);
    end

    // Debug port sees committed state only, never the bypass.
    always_comb begin
        dbg_rdata_o = `ZERO;
        if (!rst_i && (dbg_raddr_i != `ZERO_REG)) begin
            dbg_rdata_o = regs[dbg_raddr_i];
        end
    end

endmodule
